// File: rtl/vector_mem_sequencer_if.sv
// Bundle of datapath, dcache and icache signals around vector_mem_sequencer.
//   slave  : sequencer view (takes requests and cache responses; drives completion and cache
//            requests).
//   master : environment view (datapath plus caches), the mirror of slave.
// Datapath : readReq, writeReq, isVector, sdaddr, sdstore, vdaddr, vdstore -> dHit, sdload, vdload
// Dcache   : dmemREN, dmemWEN, dmemaddr, dmemstore <- dmemload, dcacheHit
// Fetch    : instReq, iaddr -> iHit, iload; imemREN, imemaddr <- imemload, icacheHit
interface vector_mem_sequencer_if #(
  parameter int unsigned THREADS = 4,
  parameter int unsigned WORD_W  = 32
);
  logic                             readReq;
  logic                             writeReq;
  logic                             isVector;
  logic [WORD_W-1:0]                sdaddr;
  logic [WORD_W-1:0]                sdstore;
  logic [THREADS-1:0][WORD_W-1:0]   vdaddr;
  logic [THREADS-1:0][WORD_W-1:0]   vdstore;
  logic                             dHit;
  logic [WORD_W-1:0]                sdload;
  logic [THREADS-1:0][WORD_W-1:0]   vdload;

  logic                             dmemREN;
  logic                             dmemWEN;
  logic [WORD_W-1:0]                dmemaddr;
  logic [WORD_W-1:0]                dmemstore;
  logic [WORD_W-1:0]                dmemload;
  logic                             dcacheHit;

  logic                             instReq;
  logic [WORD_W-1:0]                iaddr;
  logic                             iHit;
  logic [WORD_W-1:0]                iload;
  logic                             imemREN;
  logic [WORD_W-1:0]                imemaddr;
  logic [WORD_W-1:0]                imemload;
  logic                             icacheHit;

  modport slave (
    input  readReq, writeReq, isVector, sdaddr, sdstore, vdaddr, vdstore,
    output dHit, sdload, vdload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dmemload, dcacheHit,
    input  instReq, iaddr,
    output iHit, iload, imemREN, imemaddr,
    input  imemload, icacheHit
  );

  modport master (
    output readReq, writeReq, isVector, sdaddr, sdstore, vdaddr, vdstore,
    input  dHit, sdload, vdload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dmemload, dcacheHit,
    output instReq, iaddr,
    input  iHit, iload, imemREN, imemaddr,
    output imemload, icacheHit
  );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Sequences datapath memory requests onto a single-ported dcache. A scalar access issues one
// dcache transaction; a vector access issues one per lane, in lane order, then pulses dHit.
// The fetch path is a plain pass-through to the icache.
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   bus : vector_mem_sequencer_if.slave (datapath, dcache and icache signals)
module vector_mem_sequencer #(
  parameter int unsigned THREADS = 4,
  parameter int unsigned WORD_W  = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  vector_mem_sequencer_if.slave bus
);

  typedef logic [WORD_W-1:0] word_t;

  localparam int unsigned          IdxW    = $clog2(THREADS);
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(THREADS - 1);

  typedef enum logic [1:0] {StIdle, StScalar, StVector, StDone} state_e;

  state_e                          state;
  logic [IdxW-1:0]                 idx;
  logic                            is_write;
  logic                            ren;
  logic                            wen;
  logic                            dhit;
  word_t                           sdload_r;
  logic [THREADS-1:0][WORD_W-1:0]  vdload_r;
  word_t                           addr_c;
  word_t                           store_c;

  // Fetch path has no state of its own.
  assign bus.imemREN  = bus.instReq;
  assign bus.imemaddr = bus.iaddr;
  assign bus.iload    = bus.imemload;
  assign bus.iHit     = bus.icacheHit;

  // Enables and dHit are registered alongside the state so they always agree with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= StIdle;
      idx      <= '0;
      is_write <= 1'b0;
      ren      <= 1'b0;
      wen      <= 1'b0;
      dhit     <= 1'b0;
      sdload_r <= '0;
      vdload_r <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          dhit <= 1'b0;
          if (bus.readReq || bus.writeReq) begin
            // Write wins when both requests are raised together.
            is_write <= bus.writeReq;
            ren      <= ~bus.writeReq;
            wen      <= bus.writeReq;
            idx      <= '0;
            state    <= bus.isVector ? StVector : StScalar;
          end
        end
        StScalar: begin
          if (bus.dcacheHit) begin
            if (!is_write) sdload_r <= bus.dmemload;
            ren   <= 1'b0;
            wen   <= 1'b0;
            dhit  <= 1'b1;
            state <= StDone;
          end
        end
        StVector: begin
          if (bus.dcacheHit) begin
            if (!is_write) vdload_r[idx] <= bus.dmemload;
            if (idx == LastIdx) begin
              ren   <= 1'b0;
              wen   <= 1'b0;
              dhit  <= 1'b1;
              state <= StDone;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        StDone: begin
          dhit  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Address and store data follow the datapath inputs live; only the lane index is state.
  always_comb begin
    addr_c  = '0;
    store_c = '0;
    unique case (state)
      StScalar: begin
        addr_c  = bus.sdaddr;
        store_c = bus.sdstore;
      end
      StVector: begin
        addr_c  = bus.vdaddr[idx];
        store_c = bus.vdstore[idx];
      end
      default: ;
    endcase
  end

  assign bus.dmemREN   = ren;
  assign bus.dmemWEN   = wen;
  assign bus.dmemaddr  = addr_c;
  assign bus.dmemstore = store_c;
  assign bus.dHit      = dhit;
  assign bus.sdload    = sdload_r;
  assign bus.vdload    = vdload_r;

endmodule

// File: doc/vector_mem_sequencer.md
VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 SHALL have parameter THREADS, default 4: number of vector lanes, power of two, range 2..16.
REQ-002 SHALL have parameter WORD_W, default 32: data and address width, matching word_t.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RST  in  1  reset; synchronous and active-high.
REQ-005 readReq  in  1  datapath data-read request.
REQ-006 writeReq  in  1  datapath data-write request.
REQ-007 isVector  in  1  1 = per-lane vector access; 0 = scalar access.
REQ-008 sdaddr, sdstore  in  WORD_W each  scalar address and store data.
REQ-009 vdaddr[THREADS], vdstore[THREADS]  in  WORD_W each  per-lane address and store data.
REQ-010 dHit  out  1  one-cycle completion pulse to the datapath.
REQ-011 sdload  out  WORD_W  registered scalar load result.
REQ-012 vdload[THREADS]  out  WORD_W each  registered per-lane load results.
REQ-013 dmemREN, dmemWEN  out  1 each  dcache read and write enables.
REQ-014 dmemaddr, dmemstore  out  WORD_W each  dcache address and store data.
REQ-015 dmemload  in  WORD_W  dcache read data.
REQ-016 dcacheHit  in  1  dcache completes the current access this cycle.
REQ-017 instReq, iaddr  in  1, WORD_W  fetch request and fetch address.
REQ-018 iHit, iload  out  1, WORD_W  fetch completion and fetch data.
REQ-019 imemREN, imemaddr  out  1, WORD_W  icache read enable and address.
REQ-020 imemload, icacheHit  in  WORD_W, 1  icache read data and hit.

Function
REQ-021 Fetch path SHALL be combinational pass-through: imemREN=instReq, imemaddr=iaddr, iload=imemload, iHit=icacheHit.
REQ-022 Data FSM SHALL have exactly four states: IDLE, SCALAR, VECTOR, DONE.
REQ-023 In IDLE, if readReq|writeReq: SHALL latch op (write if writeReq=1, else read), go to SCALAR if isVector=0, else go to VECTOR with lane index idx=0.
REQ-024 If readReq and writeReq are both 1 in IDLE, SHALL perform a write.
REQ-025 In SCALAR: dmemaddr=sdaddr, dmemstore=sdstore, REN/WEN per latched op.
REQ-026 In SCALAR, on dcacheHit: SHALL capture dmemload into sdload (reads only) and go to DONE.
REQ-027 In VECTOR: dmemaddr=vdaddr[idx], dmemstore=vdstore[idx], REN/WEN per latched op.
REQ-028 In VECTOR, on dcacheHit: SHALL capture dmemload into vdload[idx] (reads only); if idx==THREADS-1 go to DONE, else idx+1 and stay in VECTOR.
REQ-029 Lanes SHALL be issued strictly in order 0..THREADS-1, exactly one dcache access per lane, with no lane skipped or repeated.
REQ-030 idx SHALL be $clog2(THREADS) bits wide and SHALL NOT wrap within an operation.
REQ-031 In DONE: dHit=1 for exactly one cycle, dmem enables=0, then go to IDLE.
REQ-032 dHit SHALL be 0 in every state except DONE.
REQ-033 In IDLE and DONE: dmemREN=dmemWEN=0, dmemaddr=0, dmemstore=0.
REQ-034 REN and WEN SHALL never be 1 together.
REQ-035 Latency with dcacheHit=1 every cycle: scalar dHit 2 cycles after the request is sampled; vector dHit THREADS+1 cycles after.
REQ-036 Each extra miss cycle (dcacheHit=0) SHALL add one cycle of latency; enables and address SHALL be held stable while waiting.
REQ-037 Once latched, an operation SHALL run to completion even if readReq/writeReq/isVector drop mid-operation.
REQ-038 Address and store inputs SHALL be sampled live, not latched; the datapath holds them stable until dHit.
REQ-039 If a request is still asserted in IDLE after DONE, a new operation SHALL start; the datapath must deassert on dHit to avoid this.
REQ-040 Write operations SHALL leave sdload and vdload unchanged.
REQ-041 sdload and vdload SHALL hold their values until the next read of the same kind.

Reset
REQ-042 RST=1 SHALL, at the next edge: FSM to IDLE, idx=0, sdload=0, all vdload=0.
REQ-043 After RST, dHit and the dmem enables SHALL be 0 from the cycle following that edge.
REQ-044 RST asserted mid-operation SHALL abandon the operation with no dHit pulse.
REQ-045 RST SHALL take priority over every other input.

Verification
REQ-046 Scalar read, sdaddr=0x40, dmemload=0xDEADBEEF, always hit -> dmemREN for 1 cycle at 0x40; sdload=0xDEADBEEF; dHit one cycle later.
REQ-047 Vector read, THREADS=4, vdaddr={0x0,0x4,0x8,0xC}, dmemload=addr+0x100 -> addresses issued in order 0,4,8,C; vdload={0x100,0x104,0x108,0x10C}; dHit on cycle 5.
REQ-048 Vector write with dcacheHit low for 2 cycles on lane 2 -> lane 2 address/data held for 3 cycles; dHit on cycle 7; vdload unchanged.
REQ-049 readReq=writeReq=1, scalar -> only dmemWEN asserted; sdload unchanged.
REQ-050 RST during lane 1 of a vector read -> IDLE next cycle, enables 0, no dHit, vdload all 0.
REQ-051 instReq=1, iaddr=0x200, icacheHit=1, in parallel with a vector op -> imemREN=1 and imemaddr=0x200 in the same cycle; iHit=1; data FSM unaffected.
